// File: rtl/mult_wb_buffer_pkg.sv
// Shared configuration and entry types for the multiplier writeback buffer.
// Holds config_pkg (core widths) and ariane_pkg (entry layout, default depth).
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64, TRANS_ID_BITS: 32'd3};

endpackage

package ariane_pkg;

  localparam int unsigned MULT_WB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [config_pkg::cva6_cfg_empty.XLEN-1:0]          result;
    logic [config_pkg::cva6_cfg_empty.TRANS_ID_BITS-1:0] trans_id;
  } mult_wb_entry_t;

endpackage

// File: rtl/mult_wb_fifo.sv
// In-order storage for mult/div results: pointers, occupancy count and memory.
// Outputs read as zero while empty; the memory itself is never reset.
module mult_wb_fifo
  import ariane_pkg::*;
#(
  parameter type         entry_t = mult_wb_entry_t,
  parameter int unsigned DEPTH   = MULT_WB_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  entry_t                   data_i,
  output entry_t                   data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  entry_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_push) mem[wptr] <= data_i;
  end

  always_comb begin
    data_o = '0;
    if (!empty_o) data_o = mem[rptr];
  end

endmodule

// File: rtl/mult_wb_buffer.sv
// Writeback buffer for the non-stallable mult/div unit with issue credit tracking.
// Optional macro MULT_WB_BYPASS_EN adds a zero-latency path when the buffer is empty.
module mult_wb_buffer
  import ariane_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           DEPTH   = MULT_WB_DEPTH_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             issue_fire_i,
  output logic                             issue_ready_o,
  input  logic                             in_valid_i,
  input  logic [CVA6Cfg.XLEN-1:0]          in_result_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0] in_trans_id_i,
  output logic                             wb_valid_o,
  input  logic                             wb_ready_i,
  output logic [CVA6Cfg.XLEN-1:0]          wb_result_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                             overflow_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned TIDW = CVA6Cfg.TRANS_ID_BITS;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  // Same layout as mult_wb_entry_t, sized from this instance's configuration.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [TIDW-1:0] trans_id;
  } entry_t;

  entry_t        in_entry;
  entry_t        head;
  entry_t        out_entry;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          fifo_push;
  logic          pop;

  assign in_entry = '{result: in_result_i, trans_id: in_trans_id_i};
  assign push_req = in_valid_i & ~flush_i;
  assign pop      = ~empty & wb_ready_i;

`ifdef MULT_WB_BYPASS_EN
  logic present;
  logic bypass_take;

  // Empty buffer shows the incoming result directly; it is stored only if not taken now.
  assign present     = empty & push_req;
  assign bypass_take = present & wb_ready_i;
  assign wb_valid_o  = ~empty | present;
  assign out_entry   = present ? in_entry : head;
  assign fifo_push   = push_req & ~bypass_take;
`else
  assign wb_valid_o  = ~empty;
  assign out_entry   = head;
  assign fifo_push   = push_req;
`endif

  assign wb_result_o   = out_entry.result;
  assign wb_trans_id_o = out_entry.trans_id;

  mult_wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .data_i  (in_entry),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (fifo_push && full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      inflight <= '0;
    end else begin
      case ({issue_fire_i, in_valid_i})
        2'b10:   if (inflight != CW'(DEPTH)) inflight <= inflight + CW'(1);
        2'b01:   if (inflight != '0)         inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign issue_ready_o = ((CW+1)'(count) + (CW+1)'(inflight)) < (CW+1)'(DEPTH);

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Self-checking bench for mult_wb_buffer: cycle table plus scoreboard of returned results.
module tb_mult_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_fire;
  logic        issue_ready;
  logic        in_valid;
  logic [63:0] in_result;
  logic [2:0]  in_trans_id;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_result;
  logic [2:0]  wb_trans_id;
  logic        overflow;

  always #5 clk = ~clk;

  mult_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .issue_fire_i  (issue_fire),
    .issue_ready_o (issue_ready),
    .in_valid_i    (in_valid),
    .in_result_i   (in_result),
    .in_trans_id_i (in_trans_id),
    .wb_valid_o    (wb_valid),
    .wb_ready_i    (wb_ready),
    .wb_result_o   (wb_result),
    .wb_trans_id_o (wb_trans_id),
    .overflow_o    (overflow)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [2:0]  tid;
  } exp_t;

  typedef struct {
    logic        r, fl, iss, inv, rdy;
    logic [63:0] res;
    logic [2:0]  tid;
    logic        ev, eir, eovf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   mcount = 0;
  bit   clr_pending = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic t(input logic r, fl, iss, inv, rdy, input logic [63:0] res,
                   input logic [2:0] tid, input logic ev, eir, eovf);
    tbl.push_back('{r, fl, iss, inv, rdy, res, tid, ev, eir, eovf});
  endtask

  // Drive one cycle of inputs, update the occupancy model and scoreboard, then
  // return at the following negedge so outputs can be sampled.
  task automatic drive(input logic r, fl, iss, inv, rdy, input logic [63:0] res,
                       input logic [2:0] tid);
    bit p, acc, byp;
    @(posedge clk);
    #1;
    if (clr_pending) begin
      sb.delete();
      clr_pending = 0;
    end
    rst = r; flush = fl; issue_fire = iss; in_valid = inv; wb_ready = rdy;
    in_result = res; in_trans_id = tid;
    byp = 0;
`ifdef MULT_WB_BYPASS_EN
    byp = (mcount == 0) && inv && !fl && !r && rdy;
`endif
    p   = (mcount != 0) && rdy;
    acc = inv && !fl && !r && ((mcount < DEPTH) || p || byp);
    if (acc) sb.push_back('{res, tid});
    if (r || fl) begin
      mcount = 0;
      clr_pending = 1;
    end else if (!byp) begin
      mcount = mcount + int'(acc) - int'(p);
    end
    @(negedge clk);
  endtask

  logic        hold = 0;
  logic [63:0] hres;
  logic [2:0]  htid;

  always @(negedge clk) begin
    exp_t e;
    if (hold) begin
      chk("hold_valid", 64'(wb_valid), 64'd1);
      chk("hold_result", wb_result, hres);
      chk("hold_tid", 64'(wb_trans_id), 64'(htid));
    end
    if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got result %0h with no expected entry", wb_result);
      end else begin
        e = sb.pop_front();
        chk("pop_result", wb_result, e.res);
        chk("pop_tid", 64'(wb_trans_id), 64'(e.tid));
      end
    end
    hold = (wb_valid === 1'b1) && !wb_ready && !rst && !flush;
    hres = wb_result;
    htid = wb_trans_id;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst = 1; flush = 0; issue_fire = 0; in_valid = 0; wb_ready = 0;
    in_result = '0; in_trans_id = '0;

    // Issue four ops, return them with writeback stalled, then drain in order.
    repeat (4) t(0,0,1,0,0, 64'h0, 3'd0, 0,1,0);
    t(0,0,0,1,0, 64'h11, 3'd0, 0,0,0);
    t(0,0,0,1,0, 64'h22, 3'd1, 1,0,0);
    t(0,0,0,1,0, 64'h33, 3'd2, 1,0,0);
    t(0,0,0,1,0, 64'h44, 3'd3, 1,0,0);
    t(0,0,0,0,0, 64'h0,  3'd0, 1,0,0);
    t(0,0,0,1,1, 64'h55, 3'd4, 1,0,0);  // push and pop while full
    t(0,0,0,0,1, 64'h0,  3'd0, 1,0,0);  // still full afterwards
    t(0,0,0,0,1, 64'h0,  3'd0, 1,1,0);
    t(0,0,0,0,1, 64'h0,  3'd0, 1,1,0);
    t(0,0,0,0,1, 64'h0,  3'd0, 1,1,0);
    t(0,0,0,0,1, 64'h0,  3'd0, 0,1,0);  // empty with ready: nothing moves
    t(0,0,0,0,0, 64'h0,  3'd0, 0,1,0);
    // Forced returns overflow a full, stalled buffer.
    t(0,0,0,1,0, 64'hA0, 3'd0, 0,1,0);
    t(0,0,0,1,0, 64'hA1, 3'd1, 1,1,0);
    t(0,0,0,1,0, 64'hA2, 3'd2, 1,1,0);
    t(0,0,0,1,0, 64'hA3, 3'd3, 1,1,0);
    t(0,0,0,1,0, 64'hA4, 3'd4, 1,0,0);  // dropped
    t(0,0,0,0,0, 64'h0,  3'd0, 1,0,1);
    t(0,0,0,0,1, 64'h0,  3'd0, 1,0,1);
    t(0,0,0,0,1, 64'h0,  3'd0, 1,1,1);
    t(0,0,0,0,1, 64'h0,  3'd0, 1,1,1);
    t(0,0,0,0,1, 64'h0,  3'd0, 1,1,1);
    t(0,0,0,0,0, 64'h0,  3'd0, 0,1,1);
    t(1,0,0,0,0, 64'h0,  3'd0, 0,1,1);
    t(0,0,0,0,0, 64'h0,  3'd0, 0,1,0);
    // Flush with two entries and one op in flight, plus a return on the flush cycle.
    repeat (3) t(0,0,1,0,0, 64'h0, 3'd0, 0,1,0);
    t(0,0,0,1,0, 64'hB0, 3'd0, 0,1,0);
    t(0,0,0,1,0, 64'hB1, 3'd1, 1,1,0);
    t(0,1,1,1,0, 64'hB2, 3'd2, 1,1,0);
    t(0,0,0,0,0, 64'h0,  3'd0, 0,1,0);
    // In-flight count restarts from zero after the flush.
    repeat (4) t(0,0,1,0,0, 64'h0, 3'd0, 0,1,0);
    t(0,0,0,0,0, 64'h0,  3'd0, 0,0,0);
    t(0,0,0,1,1, 64'hC0, 3'd0, 0,0,0);
    t(0,0,0,1,1, 64'hC1, 3'd1, 1,0,0);
    t(0,0,0,1,1, 64'hC2, 3'd2, 1,1,0);
    t(0,0,0,1,1, 64'hC3, 3'd3, 1,1,0);
    t(0,1,0,0,1, 64'h0,  3'd0, 1,1,0);  // flush with a pop on the same cycle
    t(0,0,0,0,1, 64'h0,  3'd0, 0,1,0);

    drive(1,0,0,0,0, 64'h0, 3'd0);
    drive(1,0,0,0,0, 64'h0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      drive(0,0,0,0,0, 64'h0, 3'd0);
      chk($sformatf("idle%0d_valid", i), 64'(wb_valid), 64'd0);
      chk($sformatf("idle%0d_ready", i), 64'(issue_ready), 64'd1);
      chk($sformatf("idle%0d_ovf", i), 64'(overflow), 64'd0);
    end
    chk("reset_result", wb_result, 64'h0);
    chk("reset_tid", 64'(wb_trans_id), 64'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.r, v.fl, v.iss, v.inv, v.rdy, v.res, v.tid);
      chk($sformatf("v%0d_valid", i), 64'(wb_valid), 64'(v.ev));
      chk($sformatf("v%0d_issue_ready", i), 64'(issue_ready), 64'(v.eir));
      chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(v.eovf));
    end

    // Empty buffer, writeback ready, single return.
    drive(0,0,0,1,1, 64'hDEAD, 3'd5);
`ifdef MULT_WB_BYPASS_EN
    chk("bypass_same_cycle", 64'(wb_valid), 64'd1);
    drive(0,0,0,0,1, 64'h0, 3'd0);
    chk("bypass_next_cycle", 64'(wb_valid), 64'd0);
`else
    chk("nobypass_same_cycle", 64'(wb_valid), 64'd0);
    drive(0,0,0,0,1, 64'h0, 3'd0);
    chk("nobypass_next_cycle", 64'(wb_valid), 64'd1);
`endif
    drive(0,0,0,0,1, 64'h0, 3'd0);
    chk("after_dead_valid", 64'(wb_valid), 64'd0);

    // Reset in the middle of traffic discards the stored entries.
    drive(0,0,0,1,0, 64'hE1, 3'd1);
    drive(0,0,0,1,0, 64'hE2, 3'd2);
    drive(1,0,0,0,0, 64'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0,0,0,0,1, 64'h0, 3'd0);
      chk($sformatf("midrst%0d_valid", i), 64'(wb_valid), 64'd0);
      chk($sformatf("midrst%0d_result", i), wb_result, 64'h0);
    end

    @(posedge clk);
    #1;
    if (clr_pending) sb.delete();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_wb_buffer.md
MULT_WB_BUFFER -- requirements
Module: mult_wb_buffer

Interface
REQ-001 The block SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, supplying XLEN and TRANS_ID_BITS.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result entries (power of two, 2..16).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port flush_i, input, 1 bit: controller flush.
REQ-006 The block SHALL have port issue_fire_i, input, 1 bit: a mult/div op was accepted by the mult unit this cycle.
REQ-007 The block SHALL have port issue_ready_o, output, 1 bit: the issue stage may send another mult/div op.
REQ-008 The block SHALL have port in_valid_i, input, 1 bit: mult unit result valid; it cannot be stalled.
REQ-009 The block SHALL have port in_result_i, input, XLEN bits: mult unit result.
REQ-010 The block SHALL have port in_trans_id_i, input, TRANS_ID_BITS bits: mult unit transaction ID.
REQ-011 The block SHALL have port wb_valid_o, output, 1 bit: a result is presented to writeback.
REQ-012 The block SHALL have port wb_ready_i, input, 1 bit: writeback accepts the result.
REQ-013 The block SHALL have port wb_result_o, output, XLEN bits: the presented result.
REQ-014 The block SHALL have port wb_trans_id_o, output, TRANS_ID_BITS bits: the presented transaction ID.
REQ-015 The block SHALL have port overflow_o, output, 1 bit: sticky error flag; set when a result is dropped.

Function
REQ-016 The block SHALL implement an in-order FIFO of DEPTH entries {result, trans_id}, with read pointer, write pointer and count.
- Pointers wrap modulo DEPTH.
- Count ranges 0..DEPTH.
REQ-017 Push SHALL occur when in_valid_i=1 and flush_i=0, provided the FIFO is not full or a pop occurs in the same cycle.
REQ-018 Pop SHALL occur when wb_valid_o=1 and wb_ready_i=1.
REQ-019 wb_valid_o SHALL equal (count!=0).
- wb_result_o and wb_trans_id_o SHALL show the head entry.
- wb_result_o and wb_trans_id_o SHALL be stable while wb_valid_o=1 and wb_ready_i=0.
REQ-020 A push into an empty FIFO SHALL be visible on wb_valid_o the next cycle, giving 1-cycle latency, except as in REQ-035.
REQ-021 An in-flight counter SHALL track ops accepted by the mult unit but not yet returned:
- +1 on issue_fire_i.
- -1 on in_valid_i.
- unchanged when both occur in the same cycle.
- saturates at 0 and at DEPTH.
REQ-022 issue_ready_o SHALL equal (count + inflight) < DEPTH. This makes overflow impossible under correct upstream use.
REQ-023 A push while full with no pop in the same cycle SHALL drop the entry and set overflow_o; overflow_o SHALL stay set until rst_i.
REQ-024 flush_i SHALL, in the next cycle, clear count, both pointers and the in-flight counter.
- The in_valid_i and issue_fire_i of the flush cycle SHALL be ignored.
- A pop on the flush cycle is still allowed.
REQ-025 When full with simultaneous push and pop, count SHALL stay at DEPTH and both pointers SHALL advance.
REQ-026 When empty with wb_ready_i=1 and no push, no state SHALL change.

Reset
REQ-027 When rst_i=1 at a clk_i edge, the block SHALL clear count, pointers, the in-flight counter and overflow_o; reset SHALL take priority over flush_i and all traffic.
REQ-028 After reset, the outputs SHALL be:
- wb_valid_o=0, wb_result_o=0, wb_trans_id_o=0.
- issue_ready_o=1.
- overflow_o=0.
REQ-029 A reset mid-operation SHALL discard all entries; no stale result SHALL appear afterwards.
REQ-030 Storage RAM contents need not be reset, but the outputs SHALL read 0 while empty.

Configuration
REQ-031 The block SHALL support macro MULT_WB_BYPASS_EN.
REQ-032 With MULT_WB_BYPASS_EN defined, when count=0, in_valid_i=1, flush_i=0 and wb_ready_i=1:
- in_result_i and in_trans_id_i SHALL be forwarded combinationally with wb_valid_o=1 in the same cycle.
- No entry SHALL be written.
REQ-033 With MULT_WB_BYPASS_EN defined, when count=0, in_valid_i=1 and wb_ready_i=0, the block SHALL present the bypass data and also push the entry, so that the entry is presented again next cycle.
REQ-034 Without MULT_WB_BYPASS_EN, the block SHALL have no input-to-output combinational path; the latency SHALL always be 1 cycle.
REQ-035 Under MULT_WB_BYPASS_EN, the zero-cycle case of REQ-032 SHALL override REQ-020.

Structure
REQ-036 The entry typedef mult_wb_entry_t {result, trans_id} SHALL be in ariane_pkg, together with the constant MULT_WB_DEPTH_DEFAULT=4.
REQ-037 The storage SHALL be the single sub-module mult_wb_fifo, holding pointers, count and memory.
REQ-038 The in-flight counter, issue_ready_o and bypass logic SHALL be in the top module.

Verification
REQ-039 Reset then idle -> wb_valid_o=0, issue_ready_o=1, overflow_o=0 for 10 cycles.
REQ-040 Issue 4 ops, hold wb_ready_i=0, return trans_id 0..3 with results 0x11..0x44:
- issue_ready_o=0 after the 4th issue.
- Release wb_ready_i -> 0x11..0x44 are popped in order on 4 consecutive cycles.
REQ-041 Full FIFO with push and pop in the same cycle -> count stays 4; order preserved.
REQ-042 Force in_valid_i while full and wb_ready_i=0 (bypassing the issue_ready_o check) -> entry dropped, overflow_o=1, held until rst_i.
REQ-043 Apply flush_i with 2 entries and 1 op in flight, plus in_valid_i in the same cycle -> next cycle wb_valid_o=0 and issue_ready_o=1.
REQ-044 Bypass check with empty FIFO and wb_ready_i=1, push result 0xDEAD:
- With MULT_WB_BYPASS_EN -> wb_valid_o in the same cycle.
- Without it -> wb_valid_o the next cycle.
